mips_hazard_controller: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS core: generates PC/pipeline-register write enables, flushes and bubble insertion for load-use stalls, taken branches resolved in MEM, and data-memory wait freezes. Also performs a post-reset boot hold and watchdogs stuck memory waits. Sits beside the datapath in `MIPS`, reading ID, EX and MEM pipeline fields and driving the enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/mips_hazard_controller_if.sv | 42 ++++
 rtl/mips_hazard_controller.sv | 165 ++++++++++++++++
 tb/tb_mips_hazard_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_hazard_controller_if.sv
// Hazard-control bundle between the MIPS datapath (master) and the hazard controller (slave).
// The master drives the pipeline fields and receives the register enables, flushes and status.
interface mips_hazard_controller_if;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_uses_rs;
    logic       ID_uses_rt;
    logic       EX_mem_read;
    logic [4:0] EX_instr_bits_20_16;
    logic       MEM_branch;
    logic       MEM_zero;
    logic       mem_busy;

    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_write;
    logic       ex_mem_write;
    logic       mem_wb_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       id_ex_bubble;
    logic       pc_src;
    logic       wait_timeout;
    logic [1:0] hazard_state;

    modport master (
        output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_mem_read, EX_instr_bits_20_16,
               MEM_branch, MEM_zero, mem_busy,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble, pc_src,
               wait_timeout, hazard_state
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_mem_read, EX_instr_bits_20_16,
               MEM_branch, MEM_zero, mem_busy,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble, pc_src,
               wait_timeout, hazard_state
    );
endinterface

// File: rtl/mips_hazard_controller.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: boot hold, load-use stall,
// MEM-resolved branch flush, memory-wait freeze and wait watchdog. Optional HAZARD_PERF_CNT_EN adds event counters.
module mips_hazard_controller #(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_WAIT    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mips_hazard_controller_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]               stall_count,
    output logic [31:0]               flush_count,
    output logic [31:0]               freeze_count
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t              state_reg, state_next;
    logic [BOOT_W-1:0]   boot_cnt_reg, boot_cnt_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                timeout_reg, timeout_next;

    logic load_use;
    logic taken;
    logic run;

    // $0 is hard-wired zero, so a load targeting it can never create a dependency.
    assign load_use = hz.EX_mem_read && (hz.EX_instr_bits_20_16 != 5'd0) &&
                      ((hz.ID_uses_rs && (hz.ID_rs == hz.EX_instr_bits_20_16)) ||
                       (hz.ID_uses_rt && (hz.ID_rt == hz.EX_instr_bits_20_16)));
    assign taken    = hz.MEM_branch && hz.MEM_zero;
    assign run      = (state_reg == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            boot_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            boot_cnt_reg <= boot_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        boot_cnt_next = boot_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        case (state_reg)
            ST_BOOT: begin
                wait_cnt_next = '0;
                if (boot_cnt_reg == BOOT_LAST) begin
                    state_next    = ST_RUN;
                    boot_cnt_next = '0;
                end else begin
                    boot_cnt_next = boot_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (hz.mem_busy) begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_next   = ST_HALT;
                        timeout_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end else begin
                    wait_cnt_next = '0;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_BOOT;
        endcase
    end

    // HALT deliberately falls through to the all-zero freeze pattern.
    always_comb begin
        hz.pc_write     = 1'b0;
        hz.if_id_write  = 1'b0;
        hz.id_ex_write  = 1'b0;
        hz.ex_mem_write = 1'b0;
        hz.mem_wb_write = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_flush = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.pc_src       = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                hz.if_id_flush  = 1'b1;
                hz.id_ex_flush  = 1'b1;
                hz.ex_mem_flush = 1'b1;
            end
            ST_RUN: begin
                if (!hz.mem_busy) begin
                    hz.id_ex_write  = 1'b1;
                    hz.ex_mem_write = 1'b1;
                    hz.mem_wb_write = 1'b1;
                    if (taken) begin
                        hz.pc_write     = 1'b1;
                        hz.if_id_write  = 1'b1;
                        hz.pc_src       = 1'b1;
                        hz.if_id_flush  = 1'b1;
                        hz.id_ex_flush  = 1'b1;
                        hz.ex_mem_flush = 1'b1;
                    end else if (load_use) begin
                        hz.id_ex_bubble = 1'b1;
                    end else begin
                        hz.pc_write     = 1'b1;
                        hz.if_id_write  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign hz.hazard_state = state_reg;
    assign hz.wait_timeout = timeout_reg;

`ifdef HAZARD_PERF_CNT_EN
    // Events follow the same priority as the output decode: freeze > branch > stall.
    logic [2:0]  perf_evt;
    logic [31:0] perf_cnt_reg [3];

    assign perf_evt[0] = run && !hz.mem_busy && !taken && load_use;
    assign perf_evt[1] = run && !hz.mem_busy && taken;
    assign perf_evt[2] = run && hz.mem_busy;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    perf_cnt_reg[gi] <= '0;
                end else if (perf_evt[gi]) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign stall_count  = perf_cnt_reg[0];
    assign flush_count  = perf_cnt_reg[1];
    assign freeze_count = perf_cnt_reg[2];
`else
    logic unused_run;
    assign unused_run = run;
`endif

endmodule

// File: tb/tb_mips_hazard_controller.sv
// Table-driven check of mips_hazard_controller with an expected-value queue, plus hand sequences
// for the memory-wait watchdog, reset-mid-stall and (with HAZARD_PERF_CNT_EN) the event counters.
module tb_mips_hazard_controller;

    // {pc_w, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_fl, id_ex_fl, ex_mem_fl, bubble, pc_src, timeout, state[1:0]}
    localparam logic [12:0] E_BOOT   = 13'b00000_111_0_0_0_00;
    localparam logic [12:0] E_RUN    = 13'b11111_000_0_0_0_01;
    localparam logic [12:0] E_STALL  = 13'b00111_000_1_0_0_01;
    localparam logic [12:0] E_BRANCH = 13'b11111_111_0_1_0_01;
    localparam logic [12:0] E_FREEZE = 13'b00000_000_0_0_0_01;
    localparam logic [12:0] E_HALT   = 13'b00000_000_0_0_1_10;

    typedef struct {
        logic        rst_n;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic        mr;
        logic [4:0]  ert;
        logic        br;
        logic        z;
        logic        busy;
        logic [12:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [12:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sbq[$];
    vec_t tbl[23];

    mips_hazard_controller_if hif();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count, flush_count, freeze_count;
    mips_hazard_controller #(.BOOT_CYCLES(2), .MAX_WAIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hif),
        .stall_count(stall_count), .flush_count(flush_count), .freeze_count(freeze_count)
    );
`else
    mips_hazard_controller #(.BOOT_CYCLES(2), .MAX_WAIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hif)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic mr,
                                 input logic [4:0] ert, input logic br, input logic z,
                                 input logic busy, input logic [12:0] exp, input string name);
        vec_t v;
        v.rst_n = r;   v.rs = rs;  v.rt = rt;   v.urs = urs; v.urt = urt;
        v.mr = mr;     v.ert = ert; v.br = br;  v.z = z;     v.busy = busy;
        v.exp = exp;   v.name = name;
        return v;
    endfunction

    function automatic vec_t idle(input logic [12:0] exp, input string name);
        return mkv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp, name);
    endfunction

    // lw $5 in EX, ID reads $5 through rs
    function automatic vec_t lu5(input logic busy, input logic [12:0] exp, input string name);
        return mkv(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, busy, exp, name);
    endfunction

    task automatic check_out();
        exp_t        e;
        logic [12:0] act;
        act = {hif.pc_write, hif.if_id_write, hif.id_ex_write, hif.ex_mem_write, hif.mem_wb_write,
               hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush, hif.id_ex_bubble, hif.pc_src,
               hif.wait_timeout, hif.hazard_state};
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: no expected entry, got %b", act);
        end else begin
            e = sbq.pop_front();
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b required %b", e.name, act, e.exp);
            end else begin
                $display("ok   %s: %b", e.name, act);
            end
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n                   = v.rst_n;
        hif.ID_rs               = v.rs;
        hif.ID_rt               = v.rt;
        hif.ID_uses_rs          = v.urs;
        hif.ID_uses_rt          = v.urt;
        hif.EX_mem_read         = v.mr;
        hif.EX_instr_bits_20_16 = v.ert;
        hif.MEM_branch          = v.br;
        hif.MEM_zero            = v.z;
        hif.mem_busy            = v.busy;
        e.exp  = v.exp;
        e.name = v.name;
        sbq.push_back(e);
        @(negedge clk);
        check_out();
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        hif.ID_rs = '0; hif.ID_rt = '0; hif.ID_uses_rs = 1'b0; hif.ID_uses_rt = 1'b0;
        hif.EX_mem_read = 1'b0; hif.EX_instr_bits_20_16 = '0;
        hif.MEM_branch = 1'b0; hif.MEM_zero = 1'b0; hif.mem_busy = 1'b0;

        tbl[0]  = mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_BOOT, "reset_hold");
        tbl[1]  = idle(E_BOOT, "boot_cycle0");
        tbl[2]  = idle(E_BOOT, "boot_cycle1");
        tbl[3]  = idle(E_RUN,  "run_cycle2");
        tbl[4]  = lu5(1'b0, E_STALL, "loaduse_rs");
        tbl[5]  = mkv(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, E_RUN, "loaduse_done");
        tbl[6]  = mkv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, "load_dest_r0");
        tbl[7]  = mkv(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_STALL, "loaduse_rt");
        tbl[8]  = mkv(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_RUN, "match_unused");
        tbl[9]  = mkv(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_BRANCH, "branch_over_lu");
        tbl[10] = mkv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, E_RUN, "branch_not_taken");
        tbl[11] = lu5(1'b1, E_FREEZE, "freeze_1");
        tbl[12] = lu5(1'b1, E_FREEZE, "freeze_2");
        tbl[13] = lu5(1'b1, E_FREEZE, "freeze_3");
        tbl[14] = lu5(1'b0, E_STALL, "loaduse_held");
        tbl[15] = idle(E_RUN, "resume");
        tbl[16] = mkv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, E_FREEZE, "freeze_over_br");
        tbl[17] = idle(E_RUN, "resume2");
        tbl[18] = lu5(1'b0, E_STALL, "stall_pre_rst");
        tbl[19] = mkv(1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_BOOT, "reset_mid_stall");
        tbl[20] = idle(E_BOOT, "reboot_c0");
        tbl[21] = idle(E_BOOT, "reboot_c1");
        tbl[22] = idle(E_RUN,  "reboot_run");

        for (int i = 0; i < 23; i++) begin
            step(tbl[i]);
        end

        // Event mix for the counters: 2 stalls, 1 taken branch, 3 freeze cycles.
        step(lu5(1'b0, E_STALL, "perf_stall1"));
        step(idle(E_RUN, "perf_gap"));
        step(lu5(1'b0, E_STALL, "perf_stall2"));
        step(mkv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_BRANCH, "perf_branch"));
        for (int i = 0; i < 3; i++) begin
            step(mkv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, E_FREEZE, "perf_freeze"));
        end
        step(idle(E_RUN, "perf_after"));
`ifdef HAZARD_PERF_CNT_EN
        check32("stall_count",  stall_count,  32'd2);
        check32("flush_count",  flush_count,  32'd1);
        check32("freeze_count", freeze_count, 32'd3);
`endif

        // One cycle short of the watchdog limit: must resume cleanly.
        for (int i = 0; i < 15; i++) begin
            step(mkv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, E_FREEZE, "wait15"));
        end
        step(idle(E_RUN, "wait15_resume"));

        for (int i = 0; i < 16; i++) begin
            step(mkv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, E_FREEZE, "wait16"));
        end
        step(idle(E_HALT, "halt_busy_dropped"));
        step(mkv(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_HALT, "halt_ignores_in"));
        step(idle(E_HALT, "halt_sticky"));
        step(mkv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_BOOT, "halt_reset"));
        step(idle(E_BOOT, "post_halt_c0"));
        step(idle(E_BOOT, "post_halt_c1"));
        step(idle(E_RUN,  "post_halt_run"));

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover required 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
